// File: rtl/input_conditioner.sv
// Push-button input conditioner: clock-enable divider, two-flop synchronizer,
// tick-sampled debounce FSM and registered level/edge outputs for a downstream
// state machine that advances on clk_en.
module input_conditioner #(
    parameter int unsigned DIV      = 4,
    parameter int unsigned DB_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic clk_en,
    output logic x,
    output logic x_rise,
    output logic x_fall
);

    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CntW = $clog2(DB_TICKS + 1);

    localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DB_TICKS);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {
        StStableLo,
        StPendHi,
        StStableHi,
        StPendLo
    } state_e;

    logic [DivW-1:0] div_q, div_d;
    logic            clk_en_q, clk_en_d;
    logic [1:0]      sync_q, sync_d;
    logic            btn_s;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic            x_q, x_d;
    logic            x_rise_q, x_rise_d;
    logic            x_fall_q, x_fall_d;

    // Divider wraps at DIV-1; the strobe is registered so it stays low in reset
    // and first rises in the DIV-th cycle after release.
    always_comb begin
        div_d    = (div_q == DivMax) ? '0 : div_q + 1'b1;
        clk_en_d = (div_q == DivMax);
    end

    // Two-flop synchronizer; btn_s is the only view of btn the FSM gets.
    always_comb begin
        sync_d = {sync_q[0], btn};
    end

    assign btn_s = sync_q[1];

    // Tick counter never wraps past DB_TICKS.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    // Debounce next-state: moves only on clk_en ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clk_en_q) begin
            unique case (state_q)
                StStableLo: begin
                    if (btn_s) begin
                        if (DB_TICKS == 1) begin
                            state_d = StStableHi;
                        end else begin
                            state_d = StPendHi;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StPendHi: begin
                    if (!btn_s) begin
                        state_d = StStableLo;
                        cnt_d   = '0;
                    end else if (cnt_inc == CntMax) begin
                        state_d = StStableHi;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StStableHi: begin
                    if (!btn_s) begin
                        if (DB_TICKS == 1) begin
                            state_d = StStableLo;
                        end else begin
                            state_d = StPendLo;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StPendLo: begin
                    if (btn_s) begin
                        state_d = StStableHi;
                        cnt_d   = '0;
                    end else if (cnt_inc == CntMax) begin
                        state_d = StStableLo;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode: x is high while the accepted level is high, edges compare
    // against the registered x so each pulse lines up with the x transition.
    always_comb begin
        x_d      = (state_q == StStableHi) || (state_q == StPendLo);
        x_rise_d = x_d & ~x_q;
        x_fall_d = ~x_d & x_q;
    end

    // Divider and synchronizer state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            clk_en_q <= 1'b0;
            sync_q   <= '0;
        end else begin
            div_q    <= div_d;
            clk_en_q <= clk_en_d;
            sync_q   <= sync_d;
        end
    end

    // Debounce FSM state and tick counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StStableLo;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs; reset clears them at once so no pulse escapes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q      <= 1'b0;
            x_rise_q <= 1'b0;
            x_fall_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            x_rise_q <= x_rise_d;
            x_fall_q <= x_fall_d;
        end
    end

    assign clk_en = clk_en_q;
    assign x      = x_q;
    assign x_rise = x_rise_q;
    assign x_fall = x_fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic btn;
    logic btn_f;
    logic clk_en, x, x_rise, x_fall;
    logic clk_en_f, x_f, x_rise_f, x_fall_f;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        bit dir;
        int cyc;
        bit pulse_ok;
        bit en_ok;
    } obs_t;

    typedef struct {
        bit dir;
        int lo;
        int hi;
    } exp_t;

    obs_t obs_q[$];
    obs_t obs_f_q[$];
    exp_t exp_q[$];
    exp_t exp_f_q[$];

    int rise_cnt    = 0;
    int fall_cnt    = 0;
    int both_cnt    = 0;
    int enf_low_cnt = 0;
    bit x_prev      = 1'b0;
    bit xf_prev     = 1'b0;
    bit en_h1       = 1'b0;
    bit en_h2       = 1'b0;

    input_conditioner dut (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn),
        .clk_en (clk_en),
        .x      (x),
        .x_rise (x_rise),
        .x_fall (x_fall)
    );

    input_conditioner #(
        .DIV      (1),
        .DB_TICKS (1)
    ) dut_f (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn_f),
        .clk_en (clk_en_f),
        .x      (x_f),
        .x_rise (x_rise_f),
        .x_fall (x_fall_f)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every x transition of both instances with pulse context.
    always @(negedge clk) begin
        if (reset) begin
            if (x !== x_prev) begin
                obs_q.push_back('{dir: x, cyc: cyc,
                                  pulse_ok: x ? (x_rise && !x_fall) : (x_fall && !x_rise),
                                  en_ok: en_h2});
            end
            if (x_f !== xf_prev) begin
                obs_f_q.push_back('{dir: x_f, cyc: cyc,
                                    pulse_ok: x_f ? (x_rise_f && !x_fall_f)
                                                  : (x_fall_f && !x_rise_f),
                                    en_ok: 1'b1});
            end
            rise_cnt    <= rise_cnt + int'(x_rise);
            fall_cnt    <= fall_cnt + int'(x_fall);
            both_cnt    <= both_cnt + int'((x_rise && x_fall) || (x_rise_f && x_fall_f));
            enf_low_cnt <= enf_low_cnt + int'(!clk_en_f);
        end
        x_prev  <= x;
        xf_prev <= x_f;
        en_h2   <= en_h1;
        en_h1   <= clk_en;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        btn   = 1'b0;
        btn_f = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({clk_en, x, x_rise, x_fall} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 0000", {clk_en, x, x_rise, x_fall});
        end
        n_tests++;
        if ({clk_en_f, x_f, x_rise_f, x_fall_f} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs_fast: got %b, expected 0000",
                     {clk_en_f, x_f, x_rise_f, x_fall_f});
        end
    endtask

    task automatic test_divider();
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_tests++;
            if (clk_en !== ((k % 4) == 0)) begin
                n_fail++;
                $display("FAIL divider_cycle%0d: got %b, expected %b", k, clk_en, (k % 4) == 0);
            end
            n_tests++;
            if (clk_en_f !== 1'b1 || x !== 1'b0) begin
                n_fail++;
                $display("FAIL divider_side%0d: got clk_en_f=%b x=%b, expected 1 0",
                         k, clk_en_f, x);
            end
        end
    endtask

    task automatic test_rise();
        int   r0;
        obs_t o;
        exp_t e;
        r0 = rise_cnt;
        btn = 1'b1;
        exp_q.push_back('{dir: 1'b1, lo: cyc + 1 + 11, hi: cyc + 1 + 14});
        repeat (30) tick();
        n_tests++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL rise_edge_count: got %0d, expected 1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (o.dir !== e.dir || o.cyc < e.lo || o.cyc > e.hi) begin
                n_fail++;
                $display("FAIL rise_latency: got dir=%0d cyc=%0d, expected dir=%0d in %0d..%0d",
                         o.dir, o.cyc, e.dir, e.lo, e.hi);
            end
            n_tests++;
            if (!o.pulse_ok || !o.en_ok) begin
                n_fail++;
                $display("FAIL rise_pulse: got pulse=%0d en=%0d, expected 1 1",
                         o.pulse_ok, o.en_ok);
            end
        end
        obs_q.delete();
        exp_q.delete();
        n_tests++;
        if (rise_cnt - r0 != 1 || x !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_once: got pulses=%0d x=%b, expected 1 1", rise_cnt - r0, x);
        end
    endtask

    task automatic test_fall_reset();
        int f0;
        f0 = fall_cnt;
        btn = 1'b0;
        repeat (8) tick();
        n_tests++;
        if (x !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_lo_hold: got x=%b, expected 1", x);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({clk_en, x, x_rise, x_fall} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_immediate: got %b, expected 0000", {clk_en, x, x_rise, x_fall});
        end
        repeat (3) tick();
        obs_q.delete();
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_tests++;
            if (clk_en !== ((k % 4) == 0) || x !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_restart%0d: got clk_en=%b x=%b, expected %b 0",
                         k, clk_en, x, (k % 4) == 0);
            end
        end
        n_tests++;
        if (fall_cnt != f0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_no_fall: got falls=%0d edges=%0d, expected 0 0",
                     fall_cnt - f0, obs_q.size());
        end
    endtask

    task automatic test_glitch();
        int r0;
        r0 = rise_cnt;
        btn = 1'b1;
        repeat (8) tick();
        btn = 1'b0;
        repeat (30) tick();
        n_tests++;
        if (obs_q.size() != 0 || rise_cnt != r0 || x !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_reject: got edges=%0d rises=%0d x=%b, expected 0 0 0",
                     obs_q.size(), rise_cnt - r0, x);
        end
        obs_q.delete();
    endtask

    task automatic test_bounce();
        obs_t o;
        exp_t e;
        int   e0;
        int   remaining;
        int   h;
        bit   target;
        bit   lvl;
        for (int t = 0; t < 4; t++) begin
            target    = ((t % 2) == 0);
            e0        = cyc + 1;
            remaining = 6;
            lvl       = target;
            while (remaining > 0) begin
                h = int'($urandom_range(1, (remaining < 3) ? remaining : 3));
                btn = lvl;
                repeat (h) tick();
                remaining -= h;
                lvl = ~lvl;
            end
            btn = target;
            exp_q.push_back('{dir: target, lo: e0 + 11, hi: cyc + 1 + 14});
            repeat (40) tick();
            n_tests++;
            if (obs_q.size() != 1) begin
                n_fail++;
                $display("FAIL bounce%0d_edge_count: got %0d, expected 1", t, obs_q.size());
            end
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                n_tests++;
                if (o.dir !== e.dir || o.cyc < e.lo || o.cyc > e.hi) begin
                    n_fail++;
                    $display("FAIL bounce%0d_edge: got dir=%0d cyc=%0d, expected dir=%0d in %0d..%0d",
                             t, o.dir, o.cyc, e.dir, e.lo, e.hi);
                end
                n_tests++;
                if (!o.pulse_ok || !o.en_ok) begin
                    n_fail++;
                    $display("FAIL bounce%0d_pulse: got pulse=%0d en=%0d, expected 1 1",
                             t, o.pulse_ok, o.en_ok);
                end
            end
            obs_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back_fast();
        obs_t o;
        exp_t e;
        int   en0;
        int   b0;
        int   idx;
        en0 = enf_low_cnt;
        b0  = both_cnt;
        obs_f_q.delete();
        exp_f_q.delete();
        for (int i = 0; i < 10; i++) begin
            btn_f = ~btn_f;
            exp_f_q.push_back('{dir: btn_f, lo: cyc + 1 + 3, hi: cyc + 1 + 3});
            repeat (int'($urandom_range(1, 4))) tick();
        end
        repeat (8) tick();
        n_tests++;
        if (obs_f_q.size() != 10) begin
            n_fail++;
            $display("FAIL fast_edge_count: got %0d, expected 10", obs_f_q.size());
        end
        idx = 0;
        while (obs_f_q.size() > 0 && exp_f_q.size() > 0) begin
            o = obs_f_q.pop_front();
            e = exp_f_q.pop_front();
            n_tests++;
            if (o.dir !== e.dir || o.cyc != e.lo || !o.pulse_ok) begin
                n_fail++;
                $display("FAIL fast_edge%0d: got dir=%0d cyc=%0d pulse=%0d, expected dir=%0d cyc=%0d pulse=1",
                         idx, o.dir, o.cyc, o.pulse_ok, e.dir, e.lo);
            end
            idx++;
        end
        n_tests++;
        if (enf_low_cnt != en0 || both_cnt != b0) begin
            n_fail++;
            $display("FAIL fast_strobe_exclusive: got en_low=%0d both=%0d, expected 0 0",
                     enf_low_cnt - en0, both_cnt - b0);
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_rise();
        test_fall_reset();
        test_glitch();
        test_bounce();
        test_back_to_back_fast();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
